// File: rtl/mc_ctrl.sv
// Multicycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB beside op_aut, with memory-timeout trap.
// Optional retired-instruction counter (o_instr_count) is built only when CTRL_PERF_EN is defined.
//
//   state  | meaning
//   IDLE   | one cycle after reset release
//   FETCH  | instruction read, waits on mem_ready
//   DECODE | opcode classification, traps illegal/halt
//   EXEC   | ALU op; branches and jumps retire here
//   MEM    | data access for lw/sw, waits on mem_ready
//   WB     | register-file write, retires R/addi/lw
//   HALT   | absorbing until reset
module mc_ctrl #(
    parameter int OPW     = 6,
    parameter int FNW     = 6,
    parameter int MEM_TMO = 15,
    parameter int CNTW    = 16
) (
    input  logic           i_clock,
    input  logic           i_reset_n,
    input  logic [OPW-1:0] i_opcode,
    input  logic [FNW-1:0] i_funct,
    input  logic           i_zero,
    input  logic           i_mem_ready,
    output logic           o_mem_req,
    output logic           o_mem_we,
    output logic           o_ir_load,
    output logic           o_pc_load,
    output logic           o_write,
    output logic [FNW-1:0] o_alu_funct,
    output logic           o_rd_mux_s,
    output logic           o_op2_mux_s,
    output logic           o_branch_mux_s,
    output logic           o_j_mux_s,
    output logic           o_halted,
    output logic           o_fault
`ifdef CTRL_PERF_EN
    ,
    output logic [CNTW-1:0] o_instr_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);
    localparam logic [FNW-1:0] FN_ADD  = FNW'(6'b100000);
    localparam logic [FNW-1:0] FN_SUB  = FNW'(6'b100010);
    localparam logic [7:0]     TMO_LAST = 8'(MEM_TMO - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_halted;
    logic       r_fault;

    logic w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_legal, w_tmo;

    assign w_is_r    = (i_opcode == OP_R);
    assign w_is_addi = (i_opcode == OP_ADDI);
    assign w_is_lw   = (i_opcode == OP_LW);
    assign w_is_sw   = (i_opcode == OP_SW);
    assign w_is_beq  = (i_opcode == OP_BEQ);
    assign w_is_j    = (i_opcode == OP_J);
    assign w_legal   = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_j;
    assign w_tmo     = (r_wait_cnt == TMO_LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH, S_MEM: begin
                    if (i_mem_ready) begin
                        r_wait_cnt <= 8'd0;
                        if (r_state == S_FETCH)  r_state <= S_DECODE;
                        else if (w_is_lw)        r_state <= S_WB;
                        else                     r_state <= S_FETCH;
                    end else if (w_tmo) begin
                        // The MEM_TMO-th consecutive miss traps; a ready on that cycle wins above.
                        r_wait_cnt <= 8'd0;
                        r_state    <= S_HALT;
                        r_halted   <= 1'b1;
                        r_fault    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        if (i_opcode != OP_HALT) r_fault <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_is_r || w_is_addi)     r_state <= S_WB;
                    else if (w_is_lw || w_is_sw) r_state <= S_MEM;
                    else                         r_state <= S_FETCH;
                end
                S_WB:   r_state <= S_FETCH;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_ir_load      = 1'b0;
        o_pc_load      = 1'b0;
        o_write        = 1'b0;
        o_alu_funct    = '0;
        o_rd_mux_s     = 1'b0;
        o_op2_mux_s    = 1'b0;
        o_branch_mux_s = 1'b0;
        o_j_mux_s      = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                o_ir_load = i_mem_ready;
            end
            S_EXEC: begin
                if (w_is_r) begin
                    o_alu_funct = i_funct;
                end else if (w_is_addi || w_is_lw || w_is_sw) begin
                    o_alu_funct = FN_ADD;
                    o_op2_mux_s = 1'b1;
                end else if (w_is_beq) begin
                    o_alu_funct    = FN_SUB;
                    o_pc_load      = 1'b1;
                    o_branch_mux_s = i_zero;
                end else if (w_is_j) begin
                    o_pc_load = 1'b1;
                    o_j_mux_s = 1'b1;
                end
            end
            S_MEM: begin
                o_mem_req   = 1'b1;
                o_op2_mux_s = 1'b1;
                o_alu_funct = FN_ADD;
                o_mem_we    = w_is_sw;
                o_pc_load   = w_is_sw & i_mem_ready;
            end
            S_WB: begin
                o_write     = 1'b1;
                o_rd_mux_s  = w_is_r;
                o_op2_mux_s = w_is_addi | w_is_lw;
                o_alu_funct = w_is_r ? i_funct : FN_ADD;
                o_pc_load   = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_halted = r_halted;
    assign o_fault  = r_fault;

`ifdef CTRL_PERF_EN
    logic [CNTW-1:0] r_instr_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)     r_instr_count <= '0;
        else if (o_pc_load) r_instr_count <= r_instr_count + 1'b1;
    end

    assign o_instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle expected traces built from instruction descriptions (directed table + random).
module tb_mc_ctrl;
    localparam int MEM_TMO = 15;
    localparam int CNTW    = 16;
    localparam logic [5:0] ADD = 6'h20, SUB = 6'h22;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [5:0] op = '0, fn = '0;
    logic       zero = 1'b0, rdy = 1'b0;
    logic       mem_req, mem_we, ir_load, pc_load, wr, rd_s, op2_s, br_s, j_s, halted, fault;
    logic [5:0] alu;
`ifdef CTRL_PERF_EN
    logic [CNTW-1:0] icnt;
`endif

    mc_ctrl #(.OPW(6), .FNW(6), .MEM_TMO(MEM_TMO), .CNTW(CNTW)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_opcode(op), .i_funct(fn), .i_zero(zero),
        .i_mem_ready(rdy), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_ir_load(ir_load),
        .o_pc_load(pc_load), .o_write(wr), .o_alu_funct(alu), .o_rd_mux_s(rd_s),
        .o_op2_mux_s(op2_s), .o_branch_mux_s(br_s), .o_j_mux_s(j_s), .o_halted(halted),
        .o_fault(fault)
`ifdef CTRL_PERF_EN
        , .o_instr_count(icnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [16:0] exp;
        string       nm;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         fw;
        int         mw;
    } ins_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_cnt = 0;

    // Packing: {req, we, ir, pc, write, rd, op2, br, j, halted, fault, alu[5:0]}
    function automatic logic [16:0] ev(input bit req, input bit we, input bit ir, input bit pc,
                                       input bit w, input bit rd, input bit o2, input bit br,
                                       input bit jj, input bit h, input bit f, input logic [5:0] a);
        return {req, we, ir, pc, w, rd, o2, br, jj, h, f, a};
    endfunction

    task automatic chk(input string nm, input logic [16:0] exp);
        logic [16:0] got;
        got = {mem_req, mem_we, ir_load, pc_load, wr, rd_s, op2_s, br_s, j_s, halted, fault, alu};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_cnt(input string nm);
`ifdef CTRL_PERF_EN
        n_checks++;
        if (icnt !== CNTW'(model_cnt)) begin
            n_errors++;
            $display("FAIL %s: instr_count got %0d expected %0d", nm, icnt, model_cnt);
        end
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    task automatic push(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r,
                        input logic [16:0] e, input string nm);
        cyc_t c;
        c.op = o; c.fn = f; c.z = z; c.rdy = r; c.exp = e; c.nm = nm;
        q.push_back(c);
    endtask

    task automatic push_fetch_decode(input logic [5:0] o, input logic [5:0] f, input int fw);
        for (int i = 0; i < fw; i++)
            push(o, f, 1'($urandom), 1'b0, ev(1,0,0,0,0,0,0,0,0,0,0,6'h0), "fetch_wait");
        push(o, f, 1'($urandom), 1'b1, ev(1,0,1,0,0,0,0,0,0,0,0,6'h0), "fetch");
        push(o, f, 1'($urandom), 1'($urandom), ev(0,0,0,0,0,0,0,0,0,0,0,6'h0), "decode");
    endtask

    // FETCH, DECODE and EXEC of a legal instruction.
    task automatic push_head(input logic [5:0] o, input logic [5:0] f, input logic z, input int fw);
        bit r, ai, lw, sw, bq, jj;
        logic [5:0] a;
        r = (o == 6'h00); ai = (o == 6'h08); lw = (o == 6'h23);
        sw = (o == 6'h2b); bq = (o == 6'h04); jj = (o == 6'h02);
        push_fetch_decode(o, f, fw);
        a = r ? f : bq ? SUB : (ai || lw || sw) ? ADD : 6'h0;
        push(o, f, z, 1'($urandom),
             ev(0,0,0, bq|jj, 0,0, ai|lw|sw, bq & z, jj, 0,0, a), "exec");
    endtask

    task automatic add_instr(input ins_t in);
        bit r, ai, lw, sw;
        r = (in.op == 6'h00); ai = (in.op == 6'h08); lw = (in.op == 6'h23); sw = (in.op == 6'h2b);
        push_head(in.op, in.fn, in.z, in.fw);
        if (lw || sw) begin
            for (int i = 0; i < in.mw; i++)
                push(in.op, in.fn, 1'($urandom), 1'b0, ev(1,sw,0,0,0,0,1,0,0,0,0,ADD), "mem_wait");
            push(in.op, in.fn, 1'($urandom), 1'b1, ev(1,sw,0,sw,0,0,1,0,0,0,0,ADD), "mem");
        end
        if (r || ai || lw)
            push(in.op, in.fn, 1'($urandom), 1'($urandom),
                 ev(0,0,0,1,1, r, ai|lw, 0,0,0,0, r ? in.fn : ADD), "wb");
        model_cnt++;
    endtask

    task automatic push_halt(input bit f, input int n);
        for (int i = 0; i < n; i++)
            push(6'($urandom), 6'($urandom), 1'($urandom), 1'b1,
                 ev(0,0,0,0,0,0,0,0,0,1,f,6'h0), "halt");
    endtask

    task automatic run_script();
        foreach (q[k]) begin
            op = q[k].op; fn = q[k].fn; zero = q[k].z; rdy = q[k].rdy;
            @(negedge clk);
            chk(q[k].nm, q[k].exp);
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        chk("in_reset", 17'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_cnt = 0;
        @(negedge clk);
        chk("idle", 17'h0);
        chk_cnt("cnt_after_reset");
        @(posedge clk);
        #1;
    endtask

    ins_t dir[9];
    logic [5:0] ops[6];

    initial begin
        ops = '{6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02};
        dir = '{
            '{6'h00, 6'h20, 1'b0, 0, 0},
            '{6'h23, 6'h11, 1'b0, 0, 3},
            '{6'h04, 6'h00, 1'b1, 0, 0},
            '{6'h04, 6'h00, 1'b0, 0, 0},
            '{6'h2b, 6'h05, 1'b0, 1, 2},
            '{6'h08, 6'h3f, 1'b1, 0, 0},
            '{6'h02, 6'h00, 1'b1, 2, 0},
            '{6'h00, 6'h22, 1'b0, MEM_TMO - 1, 0},
            '{6'h23, 6'h00, 1'b0, 0, MEM_TMO - 1}
        };

        do_reset();
        foreach (dir[i]) add_instr(dir[i]);
        run_script();
        chk_cnt("cnt_directed");

        // Illegal opcode traps with fault; count frozen.
        do_reset();
        add_instr('{6'h00, 6'h20, 1'b0, 0, 0});
        add_instr('{6'h02, 6'h00, 1'b0, 0, 0});
        add_instr('{6'h2b, 6'h00, 1'b0, 0, 0});
        push_fetch_decode(6'h33, 6'h00, 0);
        push_halt(1'b1, 3);
        run_script();
        chk_cnt("cnt_three_then_halt");

        // Halt opcode: no fault.
        do_reset();
        push_fetch_decode(6'h3f, 6'h00, 0);
        push_halt(1'b0, 3);
        run_script();

        // FETCH timeout: MEM_TMO misses then sticky fault, ready ignored afterwards.
        do_reset();
        for (int i = 0; i < MEM_TMO; i++)
            push(6'h00, 6'h00, 1'b0, 1'b0, ev(1,0,0,0,0,0,0,0,0,0,0,6'h0), "fetch_tmo");
        push_halt(1'b1, 3);
        run_script();

        // MEM timeout during lw.
        do_reset();
        push_head(6'h23, 6'h00, 1'b0, 0);
        for (int i = 0; i < MEM_TMO; i++)
            push(6'h23, 6'h00, 1'b0, 1'b0, ev(1,0,0,0,0,0,1,0,0,0,0,ADD), "mem_tmo");
        push_halt(1'b1, 3);
        run_script();
        chk_cnt("cnt_mem_tmo");

        // Reset in the middle of an R-type instruction (state WB pending).
        do_reset();
        push_head(6'h00, 6'h20, 1'b0, 0);
        run_script();
        op = 6'h00; fn = 6'h20;
        #2;
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        chk("abort_outputs", 17'h0);
        chk_cnt("abort_cnt");
        do_reset();
        add_instr('{6'h08, 6'h00, 1'b0, 0, 0});
        run_script();
        chk_cnt("cnt_after_abort");

        // Random legal instruction stream.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            ins_t in;
            in.op = ops[$urandom_range(0, 5)];
            in.fn = 6'($urandom);
            in.z  = 1'($urandom);
            in.fw = ($urandom_range(0, 9) == 0) ? MEM_TMO - 1 : int'($urandom_range(0, 3));
            in.mw = ($urandom_range(0, 9) == 0) ? MEM_TMO - 1 : int'($urandom_range(0, 3));
            add_instr(in);
            if (n % 50 == 49) begin
                run_script();
                chk_cnt("cnt_random");
            end
        end
        run_script();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
